lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage. It consumes `ex`'s load/store requests (enable, address, data, destination register) plus the access size, and serialises them onto a byte-wide RAM port. It returns loaded, extended values to the register file's memory write port. While an access is in flight it asserts `pause_signal` so the upstream pipeline holds.

---
 rtl/lsu.sv | 166 ++++++++++++++++
 tb/tb_lsu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Brief    : Load/store unit serialising word/half/byte accesses onto a
//             byte-wide RAM port, with sign/zero-extended register writeback.
//  Revision : 1.0
// ============================================================================
module lsu #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic                  store_en,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       addr,
   input  logic [XLEN-1:0]       store_data,
   input  logic [REG_ADDR_W-1:0] load_regs_addr,
   output logic [XLEN-1:0]       ram_addr,
   input  logic [7:0]            ram_rdata,
   output logic                  ram_we,
   output logic [7:0]            ram_wdata,
   output logic                  regs_write_en,
   output logic [REG_ADDR_W-1:0] regs_write_addr,
   output logic [XLEN-1:0]       regs_write_data,
   output logic                  pause_signal
);

   localparam logic [1:0] C_ST_IDLE   = 2'd0;
   localparam logic [1:0] C_ST_ACCESS = 2'd1;
   localparam logic [1:0] C_ST_WB     = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [XLEN-1:0]       base_q,  base_d;
   logic [XLEN-1:0]       data_q,  data_d;
   logic [XLEN-1:0]       res_q,   res_d;
   logic [REG_ADDR_W-1:0] dest_q,  dest_d;
   logic [2:0]            size_q,  size_d;
   logic [1:0]            idx_q,   idx_d;
   logic                  sign_q,  sign_d;
   logic                  store_q, store_d;

   logic                  w_f3_ok;
   logic                  w_req;
   logic                  w_last;
   logic [2:0]            w_size;
   logic [XLEN-1:0]       w_ext;

   always_comb begin
      w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      w_req   = (load_en || store_en) && w_f3_ok;
      case (funct3[1:0])
         2'b00:   w_size = 3'd1;
         2'b01:   w_size = 3'd2;
         default: w_size = 3'd4;
      endcase
      w_last = ({1'b0, idx_q} == (size_q - 3'd1));
   end

   // Extension keys off the captured size; upper result bytes are cleared at capture.
   always_comb begin
      case (size_q)
         3'd1:    w_ext = sign_q ? {{(XLEN-8){res_q[7]}},   res_q[7:0]}
                                 : {{(XLEN-8){1'b0}},       res_q[7:0]};
         3'd2:    w_ext = sign_q ? {{(XLEN-16){res_q[15]}}, res_q[15:0]}
                                 : {{(XLEN-16){1'b0}},      res_q[15:0]};
         default: w_ext = res_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= C_ST_IDLE;
         base_q  <= '0;
         data_q  <= '0;
         res_q   <= '0;
         dest_q  <= '0;
         size_q  <= '0;
         idx_q   <= '0;
         sign_q  <= 1'b0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         data_q  <= data_d;
         res_q   <= res_d;
         dest_q  <= dest_d;
         size_q  <= size_d;
         idx_q   <= idx_d;
         sign_q  <= sign_d;
         store_q <= store_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      data_d  = data_q;
      res_d   = res_q;
      dest_d  = dest_q;
      size_d  = size_q;
      idx_d   = idx_q;
      sign_d  = sign_q;
      store_d = store_q;
      case (state_q)
         C_ST_IDLE: begin
            if (w_req) begin
               base_d  = addr;
               data_d  = store_data;
               res_d   = '0;
               dest_d  = load_regs_addr;
               size_d  = w_size;
               idx_d   = 2'd0;
               sign_d  = ~funct3[2];
               store_d = store_en;
               state_d = C_ST_ACCESS;
            end
         end
         C_ST_ACCESS: begin
            if (!store_q) begin
               res_d[{idx_q, 3'b000} +: 8] = ram_rdata;
            end
            idx_d = idx_q + 2'd1;
            if (w_last) begin
               state_d = store_q ? C_ST_IDLE : C_ST_WB;
            end
         end
         C_ST_WB:  state_d = C_ST_IDLE;
         default:  state_d = C_ST_IDLE;
      endcase
   end

   // Outputs are forced low while reset is held so an aborted store cannot pulse ram_we.
   always_comb begin
      ram_addr        = '0;
      ram_we          = 1'b0;
      ram_wdata       = '0;
      regs_write_en   = 1'b0;
      regs_write_addr = '0;
      regs_write_data = '0;
      pause_signal    = 1'b0;
      if (rst) begin
         case (state_q)
            C_ST_IDLE: pause_signal = w_req;
            C_ST_ACCESS: begin
               pause_signal = 1'b1;
               ram_addr     = base_q + {{(XLEN-2){1'b0}}, idx_q};
               if (store_q) begin
                  ram_we    = 1'b1;
                  ram_wdata = data_q[{idx_q, 3'b000} +: 8];
               end
            end
            C_ST_WB: begin
               regs_write_en   = (dest_q != '0);
               regs_write_addr = dest_q;
               regs_write_data = w_ext;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Brief    : Self-checking bench for lsu against a byte-addressed memory model.
//  Revision : 1.0
// ============================================================================
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en, store_en;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [4:0]  load_regs_addr;
   logic [31:0] ram_addr;
   logic [7:0]  ram_rdata;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic        regs_write_en;
   logic [4:0]  regs_write_addr;
   logic [31:0] regs_write_data;
   logic        pause_signal;

   int n_vec = 0;
   int n_err = 0;

   // Physical RAM seen by the DUT (12-bit aliased) and the reference byte map.
   bit [7:0] mem [4096];
   bit [7:0] ref_mem [bit [31:0]];

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[11:0]];
   always @(posedge clk) if (ram_we) mem[ram_addr[11:0]] <= ram_wdata;

   lsu #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .load_regs_addr(load_regs_addr), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .ram_we(ram_we), .ram_wdata(ram_wdata), .regs_write_en(regs_write_en),
      .regs_write_addr(regs_write_addr), .regs_write_data(regs_write_data),
      .pause_signal(pause_signal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit f3_valid(input logic [2:0] f);
      return f == 3'b000 || f == 3'b001 || f == 3'b010 || f == 3'b100 || f == 3'b101;
   endfunction

   function automatic int f3_bytes(input logic [2:0] f);
      return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit [7:0] ref_rd(input bit [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Little-endian assembly then two's-complement adjustment for signed sizes.
   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
      longint v = 0;
      int     n = f3_bytes(f);
      for (int i = 0; i < n; i++) begin
         bit [31:0] ai = a + 32'(i);
         v += longint'(ref_rd(ai)) << (8 * i);
      end
      if (!f[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic run_req(input logic ld, input logic st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      logic        pz [7];
      logic        we [7];
      logic        wbe[7];
      logic [31:0] ra [7];
      logic [7:0]  wd [7];
      logic [4:0]  wba[7];
      logic [31:0] wbd[7];
      bit          valid = (ld || st) && f3_valid(f);
      bit          isst  = st;
      int          n     = f3_bytes(f);
      logic [31:0] exp_ld = model_load(a, f);
      logic [31:0] eaddr;
      logic [31:0] dsh;

      @(negedge clk);
      load_en = ld; store_en = st; funct3 = f; addr = a; store_data = d; load_regs_addr = rd;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) begin load_en = 1'b0; store_en = 1'b0; end
         #1;
         pz[c] = pause_signal; we[c] = ram_we; ra[c] = ram_addr; wd[c] = ram_wdata;
         wbe[c] = regs_write_en; wba[c] = regs_write_addr; wbd[c] = regs_write_data;
         @(negedge clk);
      end

      for (int c = 0; c < 7; c++) begin
         bit acc = valid && c >= 1 && c <= n;
         eaddr = a + 32'(c - 1);
         check("pause", {31'b0, pz[c]}, {31'b0, valid && c <= n});
         check("ram_we", {31'b0, we[c]}, {31'b0, acc && isst});
         if (acc) check("ram_addr", ra[c], eaddr);
         if (acc && isst) begin
            dsh = d >> (8 * (c - 1));
            check("ram_wdata", {24'b0, wd[c]}, {24'b0, dsh[7:0]});
         end
         check("wb_en", {31'b0, wbe[c]}, {31'b0, valid && !isst && rd != 5'd0 && c == n + 1});
         if (valid && !isst && rd != 5'd0 && c == n + 1) begin
            check("wb_addr", {27'b0, wba[c]}, {27'b0, rd});
            check("wb_data", wbd[c], exp_ld);
         end
      end

      if (valid && isst) begin
         for (int i = 0; i < n; i++) begin
            bit [31:0] ai = a + 32'(i);
            dsh = d >> (8 * i);
            ref_mem[ai] = dsh[7:0];
         end
      end
   endtask

   initial begin
      rst = 1'b0; load_en = 1'b1; store_en = 1'b1; funct3 = 3'b010;
      addr = 32'h100; store_data = 32'hFFFF_FFFF; load_regs_addr = 5'd3;

      // Reset held for two edges with requests driven.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         check("rst_we", {31'b0, ram_we}, 32'd0);
         check("rst_pause", {31'b0, pause_signal}, 32'd0);
         check("rst_wb", {31'b0, regs_write_en}, 32'd0);
         check("rst_raddr", ram_addr, 32'd0);
      end
      @(negedge clk);
      load_en = 1'b0; store_en = 1'b0; rst = 1'b1;
      #1;
      check("post_rst_pause", {31'b0, pause_signal}, 32'd0);
      check("post_rst_we", {31'b0, ram_we}, 32'd0);
      check("post_rst_wbdata", regs_write_data, 32'd0);
      check("post_rst_wdata", {24'b0, ram_wdata}, 32'd0);

      // Word store/load round trip.
      run_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
      run_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);

      // Sign/zero extension including a misaligned halfword.
      run_req(1'b0, 1'b1, 3'b000, 32'h200, 32'h80, 5'd0);
      run_req(1'b0, 1'b1, 3'b000, 32'h1FF, 32'h01, 5'd0);
      run_req(1'b1, 1'b0, 3'b000, 32'h200, 32'h0, 5'd1);
      run_req(1'b1, 1'b0, 3'b100, 32'h200, 32'h0, 5'd2);
      run_req(1'b1, 1'b0, 3'b001, 32'h1FF, 32'h0, 5'd3);
      run_req(1'b1, 1'b0, 3'b101, 32'h1FF, 32'h0, 5'd4);

      // Both enables: store wins, no writeback.
      run_req(1'b1, 1'b1, 3'b000, 32'h10, 32'h55, 5'd7);
      run_req(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 5'd8);

      // Address wrap across 2^32.
      run_req(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'h4433_2211, 5'd0);
      run_req(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 5'd9);

      // Load to x0 and an invalid size code.
      run_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd0);
      run_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd6);

      // Reset during a word store after two bytes have gone out.
      @(negedge clk);
      store_en = 1'b1; funct3 = 3'b010; addr = 32'h300; store_data = 32'h1122_3344;
      #1 check("mr_pause0", {31'b0, pause_signal}, 32'd1);
      @(negedge clk);
      store_en = 1'b0;
      #1 check("mr_we1", {31'b0, ram_we}, 32'd1);
      check("mr_wd1", {24'b0, ram_wdata}, 32'h44);
      @(negedge clk);
      #1 check("mr_we2", {31'b0, ram_we}, 32'd1);
      check("mr_wd2", {24'b0, ram_wdata}, 32'h33);
      @(negedge clk);
      rst = 1'b0;
      #1 check("mr_we_rst", {31'b0, ram_we}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("mr_we_after", {31'b0, ram_we}, 32'd0);
         check("mr_pause_after", {31'b0, pause_signal}, 32'd0);
         check("mr_wb_after", {31'b0, regs_write_en}, 32'd0);
         @(negedge clk);
      end
      ref_mem[32'h300] = 8'h44;
      ref_mem[32'h301] = 8'h33;
      run_req(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9);

      // Randomised traffic in a small window so loads hit earlier stores.
      for (int k = 0; k < 40; k++) begin
         run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 32'h400 + 32'($urandom_range(0, 63)),
                 $urandom, 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
